regfile_mp: RTL

Parametrised multi-port general-purpose register file for the CPU core, the successor to the fixed 2-read/1-write 32×32 file. It provides NUM_RD combinational read ports and two write ports, keeps register 0 hard-wired to zero, and tracks a per-register busy scoreboard so the issue stage can detect pending writes. After reset it clears its storage with a sequential sweep. Decode/issue sits on the read side; the writeback stage drives the write ports.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_mp.sv | 130 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// the all-zero word and the clear-sweep FSM encoding.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_NUM_WR = 2;

    localparam logic [REGFILE_DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file. One bit per register marks a
// pending producer; a reservation is newer than any same-cycle write, so
// set wins over clear. Register 0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = REGFILE_NUM_WR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic [NUM_WR-1:0]        clr_en,
    input  logic [NUM_WR*ADDR_W-1:0] clr_addr,
    input  logic [NUM_RD-1:0]        lookup_en,
    input  logic [NUM_RD*ADDR_W-1:0] lookup_addr,
    output logic [NUM_RD-1:0]        busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_next;

    // Clear on completed writes first, then apply the newer reservation
    always_comb begin
        busy_next = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (clr_en[k]) begin
                busy_next[clr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy vector register, wiped by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    // Per-read-port lookups reflect registered state only
    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            busy[i] = lookup_en[i] & busy_q[lookup_addr[i*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write
// ports (port 1 wins on collision), r0 hard-wired to zero, a busy
// scoreboard and a post-reset clear sweep.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to matching reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready_o,
    input  logic [1:0]                 wr_en_i,
    input  logic [2*ADDR_W-1:0]        wr_addr_i,
    input  logic [2*DATA_W-1:0]        wr_data_i,
    input  logic [NUM_RD-1:0]          rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    input  logic                       rsv_en_i,
    input  logic [ADDR_W-1:0]          rsv_addr_i,
    output logic [NUM_RD-1:0]          busy_o
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int NUM_WR = REGFILE_NUM_WR;

    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic              sweep_done;
    logic              run;
    logic [NUM_WR-1:0] wr_ok;
    logic [DATA_W-1:0] mem [DEPTH];

    assign sweep_done = (clr_cnt == {ADDR_W{1'b1}});

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Leave INIT once the last register is being cleared
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (sweep_done) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // FSM outputs
    always_comb begin
        run     = (state == ST_RUN);
        ready_o = run;
    end

    // Clear-sweep address counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_cnt <= '0;
        end else if (state == ST_INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // A write port is effective only in RUN and never to r0
    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_ok[k] = run && wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Storage: sweep clears in INIT; in RUN higher port index is applied last
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_INIT) begin
                mem[clr_cnt] <= ZERO_WORD;
            end else begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_ok[k]) begin
                        mem[wr_addr_i[k*ADDR_W +: ADDR_W]] <= wr_data_i[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Read muxes: zero for disabled/r0/INIT, then optional bypass, else storage
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (run && rd_en_i[i] && (rd_addr_i[i*ADDR_W +: ADDR_W] != '0)) begin
                rd_data_o[i*DATA_W +: DATA_W] = mem[rd_addr_i[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_ok[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] == rd_addr_i[i*ADDR_W +: ADDR_W])) begin
                        rd_data_o[i*DATA_W +: DATA_W] = wr_data_i[k*DATA_W +: DATA_W];
                    end
                end
`endif
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (run & rsv_en_i),
        .set_addr    (rsv_addr_i),
        .clr_en      (wr_ok),
        .clr_addr    (wr_addr_i),
        .lookup_en   (rd_en_i & {NUM_RD{run}}),
        .lookup_addr (rd_addr_i),
        .busy        (busy_o)
    );

endmodule
